featuremap_accum_relu: RTL

Parametrised successor to the fixed 8-channel featuremap filter block: joins CHANNELS per-channel conv2D partial-result streams, sums them in a registered adder tree, and adds one bias per output feature map. It then saturates, optionally applies ReLU, and emits one pixel per handshake with downstream backpressure and frame position tracking. It sits between the per-channel conv2D instances (via their show-ahead FIFOs) and the next layer's line buffers or pooling block. Arithmetic is signed two's-complement fixed point, so no floating-point adders are needed.

---
 rtl/featuremap_accum_relu.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/featuremap_accum_relu.sv
// featuremap_accum_relu
//   Joins CHANNELS conv2D partial-result streams, sums them in a registered
//   adder tree, adds a per-feature-map bias, saturates to DATA_WIDTH, applies
//   optional ReLU, and emits one pixel per valid/ready handshake with frame
//   position tracking.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              synchronous active-high reset
//   data_in          packed FIFO heads, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_fifo_empty  per-channel FIFO empty flags
//   rdreq            common read strobe; a word is consumed in the same cycle
//   data_out         result pixel (signed)
//   valid_out        data_out is valid
//   ready_in         downstream accepts data_out
//   last_out         final beat of a frame (row HEIGHT-1, col WIDTH-1)
module featuremap_accum_relu #(
  parameter int                            DATA_WIDTH = 32,
  parameter int                            CHANNELS   = 8,
  parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
  parameter int                            RELU       = 1,
  parameter int                            WIDTH      = 56,
  parameter int                            HEIGHT     = 56
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]            data_fifo_empty,
  output logic                           rdreq,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           last_out
);

  localparam int T  = (CHANNELS > 1) ? $clog2(CHANNELS) : 0;
  localparam int SW = DATA_WIDTH + T + 1;
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic signed [SW-1:0] MAXV = SW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  // Number of operands held at tree level l (level 0 is the capture stage).
  function automatic int lvl_cnt(input int l);
    return (CHANNELS + (1 << l) - 1) >> l;
  endfunction

  logic                  w_stall;
  logic                  w_rd;
  logic signed [SW-1:0]  w_b;
  logic [DATA_WIDTH-1:0] w_res;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;

  assign w_stall = r_valid_out & ~ready_in;
  assign w_rd    = ~rst & ~w_stall & ~(|data_fifo_empty);
  assign rdreq   = w_rd;

  // Every level is kept at the final width SW; operands are sign-extended on
  // entry, so each level's value equals its narrower DATA_WIDTH+l+1 form.
  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int N = lvl_cnt(l);
    logic signed [SW-1:0] r_d [N];
    logic signed [SW-1:0] w_n [N];
    logic                 r_v;

    if (l == 0) begin : g_cap
      for (genvar j = 0; j < N; j++) begin : g_j
        assign w_n[j] = SW'($signed(data_in[j*DATA_WIDTH +: DATA_WIDTH]));
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (!w_stall) begin
          r_v <= w_rd;
          if (w_rd) r_d <= w_n;
        end
      end
    end else begin : g_add
      localparam int NP = lvl_cnt(l - 1);
      for (genvar j = 0; j < N; j++) begin : g_j
        if (2*j + 1 < NP) begin : g_pair
          assign w_n[j] = g_lvl[l-1].r_d[2*j] + g_lvl[l-1].r_d[2*j+1];
        end else begin : g_pass
          assign w_n[j] = g_lvl[l-1].r_d[2*j];
        end
      end
      always_ff @(posedge clk) begin
        if (rst) begin
          r_v <= 1'b0;
        end else if (!w_stall) begin
          r_v <= g_lvl[l-1].r_v;
          r_d <= w_n;
        end
      end
    end
  end

  // Bias, saturate to DATA_WIDTH, then optional ReLU.
  assign w_b = g_lvl[T].r_d[0] + SW'(BIAS);

  always_comb begin
    w_res = w_b[DATA_WIDTH-1:0];
    if (w_b > MAXV)      w_res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (w_b < MINV) w_res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    if (RELU != 0 && w_b[SW-1]) w_res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else if (!w_stall) begin
      r_valid_out <= g_lvl[T].r_v;
      if (g_lvl[T].r_v) r_data_out <= w_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_valid_out && ready_in) begin
      if (r_col == CW'(WIDTH - 1)) begin
        r_col <= '0;
        r_row <= (r_row == RW'(HEIGHT - 1)) ? RW'(0) : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign last_out  = r_valid_out & (r_row == RW'(HEIGHT - 1)) & (r_col == CW'(WIDTH - 1));

endmodule
